// File: rtl/perf_event_counter_if.sv
// Dump port of the performance event counter.
// Carries the counter snapshot stream from the counter block to a consumer
// (bench or debug unit) with a plain valid/ready handshake.
//   dump_valid : dump word is valid                    (master -> slave)
//   dump_ready : consumer accepts the dump word         (slave  -> master)
//   dump_idx   : word index, NUM_CH = cycle counter     (master -> slave)
//   dump_data  : counter value for dump_idx             (master -> slave)
interface perf_event_counter_if #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 32
);

    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [CNT_W-1:0] dump_data;

    // Counter side: produces the snapshot words.
    modport master (
        output dump_valid,
        output dump_idx,
        output dump_data,
        input  dump_ready
    );

    // Consumer side: accepts the snapshot words.
    modport slave (
        input  dump_valid,
        input  dump_idx,
        input  dump_data,
        output dump_ready
    );

endinterface

// File: rtl/perf_event_counter.sv
// Performance event counter.
// Counts NUM_CH single-bit event strobes plus a free-running cycle counter
// while the core runs. A halt strobe freezes all counts (the halt cycle is
// still counted) and the snapshot is streamed out over the dump interface,
// one word per accepted handshake, channel 0 first and the cycle counter
// last. Overflow flags are sticky; arithmetic either wraps or saturates.
// Ports:
//   clk   : clock
//   rst   : asynchronous, active-high reset
//   clr   : synchronous clear of counters, flags and state (wins over all)
//   en    : global count enable
//   evt   : NUM_CH event strobes, sampled each clk
//   halt  : processor halt strobe, starts the dump
//   dump  : valid/ready dump port (master modport)
//   ovf   : sticky overflow flags, bit NUM_CH = cycle counter
//   done  : dump complete, counts frozen
module perf_event_counter #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        en,
    input  logic [NUM_CH-1:0]           evt,
    input  logic                        halt,
    perf_event_counter_if.master        dump,
    output logic [NUM_CH:0]             ovf,
    output logic                        done
);

    // Event channels plus the cycle counter in the top slot.
    localparam int unsigned NUM_CTR = NUM_CH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);

    typedef enum logic [1:0] {
        RUN,
        DUMP,
        DONE
    } stateT;

    stateT            stateQ;
    stateT            stateD;
    logic [CNT_W-1:0] cntQ [NUM_CTR];
    logic [CNT_W-1:0] cntD [NUM_CTR];
    logic [NUM_CH:0]  ovfQ;
    logic [NUM_CH:0]  ovfD;
    logic [IDX_W-1:0] ptrQ;
    logic [IDX_W-1:0] ptrD;
    logic             validQ;
    logic             validD;
    logic [CNT_W-1:0] dataQ;
    logic [CNT_W-1:0] dataD;
    logic             doneQ;
    logic             doneD;

    logic [NUM_CH:0]  incVec;
    logic [IDX_W-1:0] nextPtr;
    logic [CNT_W-1:0] nextWord;

    // The cycle counter sees a constant strobe.
    assign incVec  = {1'b1, evt};
    assign nextPtr = ptrQ + IDX_W'(1);

    // Counter value for the word following the current one.
    always_comb begin
        nextWord = '0;
        for (int i = 0; i < int'(NUM_CTR); i++) begin
            if (nextPtr == IDX_W'(i)) begin
                nextWord = cntQ[i];
            end
        end
    end

    // State, counter and dump register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= RUN;
            for (int i = 0; i < int'(NUM_CTR); i++) begin
                cntQ[i] <= '0;
            end
            ovfQ   <= '0;
            ptrQ   <= '0;
            validQ <= 1'b0;
            dataQ  <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            for (int i = 0; i < int'(NUM_CTR); i++) begin
                cntQ[i] <= cntD[i];
            end
            ovfQ   <= ovfD;
            ptrQ   <= ptrD;
            validQ <= validD;
            dataQ  <= dataD;
            doneQ  <= doneD;
        end
    end

    // Next-state, counting and dump sequencing.
    always_comb begin
        stateD = stateQ;
        for (int i = 0; i < int'(NUM_CTR); i++) begin
            cntD[i] = cntQ[i];
        end
        ovfD   = ovfQ;
        ptrD   = ptrQ;
        validD = validQ;
        dataD  = dataQ;
        doneD  = doneQ;

        case (stateQ)
            RUN: begin
                if (en) begin
                    for (int i = 0; i < int'(NUM_CTR); i++) begin
                        if (incVec[i]) begin
                            if (cntQ[i] == {CNT_W{1'b1}}) begin
                                ovfD[i] = 1'b1;
                                cntD[i] = (SATURATE != 0) ? cntQ[i] : '0;
                            end else begin
                                cntD[i] = cntQ[i] + CNT_W'(1);
                            end
                        end
                    end
                end
                // First dump word must already include the halt cycle.
                if (halt) begin
                    stateD = DUMP;
                    validD = 1'b1;
                    ptrD   = '0;
                    dataD  = cntD[0];
                end
            end

            DUMP: begin
                if (dump.dump_ready) begin
                    if (ptrQ == LAST_IDX) begin
                        stateD = DONE;
                        validD = 1'b0;
                        doneD  = 1'b1;
                    end else begin
                        ptrD  = nextPtr;
                        dataD = nextWord;
                    end
                end
            end

            DONE: begin
                // Frozen until clr or rst.
            end

            default: begin
                stateD = RUN;
            end
        endcase

        // Clear overrides everything decided above.
        if (clr) begin
            stateD = RUN;
            for (int i = 0; i < int'(NUM_CTR); i++) begin
                cntD[i] = '0;
            end
            ovfD   = '0;
            ptrD   = '0;
            validD = 1'b0;
            dataD  = '0;
            doneD  = 1'b0;
        end
    end

    assign dump.dump_valid = validQ;
    assign dump.dump_idx   = ptrQ;
    assign dump.dump_data  = dataQ;
    assign ovf             = ovfQ;
    assign done            = doneQ;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: a wrapping and a saturating instance share
// all inputs; expected dump words are queued at halt and popped on each
// accepted handshake.
module tb_perf_event_counter;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned IW  = 4;

    typedef struct {
        logic [3:0]      pat;
        int              n;
        logic            alt;
        logic [3:0]      haltEvt;
        int              stallIdx;
        logic [4:0][7:0] expW;
        logic [4:0][7:0] expS;
        logic [4:0]      ovfE;
    } vecT;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] dW;
        logic [7:0] dS;
    } wordT;

    logic clk = 1'b0;
    logic rst, clr, en, halt, ready;
    logic [NCH-1:0] evt;
    logic [NCH:0] ovfW, ovfS;
    logic doneW, doneS;

    int total = 0;
    int bad   = 0;
    wordT q[$];
    vecT vecs[5];

    perf_event_counter_if #(.IDX_W(IW), .CNT_W(CW)) busW ();
    perf_event_counter_if #(.IDX_W(IW), .CNT_W(CW)) busS ();

    assign busW.dump_ready = ready;
    assign busS.dump_ready = ready;

    perf_event_counter #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(0), .IDX_W(IW)) dutW (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .evt(evt), .halt(halt),
        .dump(busW), .ovf(ovfW), .done(doneW)
    );

    perf_event_counter #(.NUM_CH(NCH), .CNT_W(CW), .SATURATE(1), .IDX_W(IW)) dutS (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .evt(evt), .halt(halt),
        .dump(busS), .ovf(ovfS), .done(doneS)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pushWords(input logic [4:0][7:0] w, input logic [4:0][7:0] s);
        wordT e;
        for (int k = 0; k < 5; k++) begin
            e.idx = 4'(k);
            e.dW  = w[k];
            e.dS  = s[k];
            q.push_back(e);
        end
    endtask

    // Drain the dump, optionally stalling 3 cycles on one index.
    task automatic collect(input int stallIdx, input logic [4:0] ovfWantW, input logic [4:0] ovfWantS);
        int hs = 0;
        int stalls = 0;
        int guard = 0;
        wordT w;
        while (q.size() > 0 && guard < 60) begin
            guard++;
            ready = (stallIdx >= 0 && int'(busW.dump_idx) == stallIdx && stalls < 3) ? 1'b0 : 1'b1;
            if (!ready) stalls++;
            if (busW.dump_valid && busS.dump_valid) begin
                w = q[0];
                check("dump_idx_wrap", 32'(busW.dump_idx), 32'(w.idx));
                check("dump_idx_sat", 32'(busS.dump_idx), 32'(w.idx));
                check("dump_data_wrap", 32'(busW.dump_data), 32'(w.dW));
                check("dump_data_sat", 32'(busS.dump_data), 32'(w.dS));
                if (ready) begin
                    void'(q.pop_front());
                    hs++;
                end
            end else begin
                check("dump_valid_high", {30'b0, busW.dump_valid, busS.dump_valid}, 32'h3);
            end
            tick();
        end
        ready = 1'b0;
        check("dump_drained", 32'(q.size()), 32'd0);
        q.delete();
        check("handshakes", 32'(hs), 32'd5);
        check("stall_cycles", 32'(stalls), (stallIdx >= 0) ? 32'd3 : 32'd0);
        check("done_wrap", 32'(doneW), 32'd1);
        check("done_sat", 32'(doneS), 32'd1);
        check("valid_after_dump", {30'b0, busW.dump_valid, busS.dump_valid}, 32'd0);
        check("ovf_wrap", 32'(ovfW), 32'(ovfWantW));
        check("ovf_sat", 32'(ovfS), 32'(ovfWantS));
    endtask

    task automatic runRec(input vecT r);
        clr = 1'b1; en = 1'b0; evt = '0; halt = 1'b0;
        tick();
        clr = 1'b0;
        for (int n = 0; n < r.n; n++) begin
            en  = r.alt ? ((n % 2) == 0) : 1'b1;
            evt = r.pat;
            tick();
        end
        halt = 1'b1; en = 1'b1; evt = r.haltEvt;
        pushWords(r.expW, r.expS);
        tick();
        halt = 1'b0; en = 1'b0; evt = '0;
        collect(r.stallIdx, r.ovfE, r.ovfE);
    endtask

    initial begin
        // Words are {idx4(cycles), idx3, idx2, idx1, idx0}.
        vecs[0] = '{pat:4'b0101, n:10, alt:1'b0, haltEvt:4'b0000, stallIdx:-1,
                    expW:{8'd11, 8'd0, 8'd10, 8'd0, 8'd10},
                    expS:{8'd11, 8'd0, 8'd10, 8'd0, 8'd10}, ovfE:5'b00000};
        vecs[1] = '{pat:4'b0000, n:3, alt:1'b0, haltEvt:4'b0010, stallIdx:-1,
                    expW:{8'd4, 8'd0, 8'd0, 8'd1, 8'd0},
                    expS:{8'd4, 8'd0, 8'd0, 8'd1, 8'd0}, ovfE:5'b00000};
        vecs[2] = '{pat:4'b1111, n:5, alt:1'b0, haltEvt:4'b1000, stallIdx:2,
                    expW:{8'd6, 8'd6, 8'd5, 8'd5, 8'd5},
                    expS:{8'd6, 8'd6, 8'd5, 8'd5, 8'd5}, ovfE:5'b00000};
        vecs[3] = '{pat:4'b0110, n:8, alt:1'b1, haltEvt:4'b0000, stallIdx:-1,
                    expW:{8'd5, 8'd0, 8'd4, 8'd4, 8'd0},
                    expS:{8'd5, 8'd0, 8'd4, 8'd4, 8'd0}, ovfE:5'b00000};
        vecs[4] = '{pat:4'b0001, n:256, alt:1'b0, haltEvt:4'b0001, stallIdx:-1,
                    expW:{8'd1, 8'd0, 8'd0, 8'd0, 8'd1},
                    expS:{8'd255, 8'd0, 8'd0, 8'd0, 8'd255}, ovfE:5'b10001};

        rst = 1'b1; clr = 1'b0; en = 1'b0; halt = 1'b0; ready = 1'b0; evt = '0;
        tick();
        tick();
        check("rst_valid", {30'b0, busW.dump_valid, busS.dump_valid}, 32'd0);
        check("rst_idx", 32'(busW.dump_idx), 32'd0);
        check("rst_data", 32'(busW.dump_data), 32'd0);
        check("rst_done", {30'b0, doneW, doneS}, 32'd0);
        check("rst_ovf", 32'(ovfW), 32'd0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            runRec(vecs[v]);
            if (v == 0) begin
                // Halt while DONE must be ignored.
                halt = 1'b1; en = 1'b1; evt = '1;
                tick();
                halt = 1'b0; en = 1'b0; evt = '0;
                tick();
                check("done_ignores_halt", 32'(doneW), 32'd1);
                check("done_no_valid", 32'(busW.dump_valid), 32'd0);
            end
        end

        // clr and halt together: clr wins, state RUN, everything zero.
        clr = 1'b1; halt = 1'b1; en = 1'b1; evt = '1; ready = 1'b1;
        tick();
        clr = 1'b0; halt = 1'b0; en = 1'b0; evt = '0; ready = 1'b0;
        check("clr_halt_valid", {30'b0, busW.dump_valid, busS.dump_valid}, 32'd0);
        check("clr_halt_done", {30'b0, doneW, doneS}, 32'd0);
        check("clr_halt_ovf_wrap", 32'(ovfW), 32'd0);
        check("clr_halt_ovf_sat", 32'(ovfS), 32'd0);
        check("clr_halt_data", 32'(busW.dump_data), 32'd0);
        // Halt with en low counts nothing: all-zero snapshot proves counts were cleared.
        halt = 1'b1;
        pushWords({8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        tick();
        halt = 1'b0;
        collect(-1, 5'b00000, 5'b00000);

        // Asynchronous reset in the middle of a dump.
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; evt = 4'b0011;
        tick();
        tick();
        halt = 1'b1; evt = '0;
        tick();
        halt = 1'b0; en = 1'b0;
        check("mid_idx0", 32'(busW.dump_idx), 32'd0);
        check("mid_data0", 32'(busW.dump_data), 32'd2);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check("mid_idx1", 32'(busW.dump_idx), 32'd1);
        check("mid_data1", 32'(busW.dump_data), 32'd2);
        check("mid_valid", 32'(busW.dump_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_valid", {30'b0, busW.dump_valid, busS.dump_valid}, 32'd0);
        check("async_done", {30'b0, doneW, doneS}, 32'd0);
        check("async_idx", 32'(busW.dump_idx), 32'd0);
        check("async_data", 32'(busW.dump_data), 32'd0);
        #1;
        rst = 1'b0;
        en = 1'b1; evt = 4'b0001;
        tick();
        tick();
        tick();
        halt = 1'b1; evt = '0;
        pushWords({8'd4, 8'd0, 8'd0, 8'd0, 8'd3}, {8'd4, 8'd0, 8'd0, 8'd0, 8'd3});
        tick();
        halt = 1'b0; en = 1'b0;
        collect(-1, 5'b00000, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perf_event_counter.md
Name: perf_event_counter

Overview:
- Synthesizable, parametrised replacement for the bench-side instruction and cache event counting; lives inside proc_hier next to the core.
- Counts up to NUM_CH single-bit event strobes per cycle (retire, ICacheReq/Hit, DCacheReq/Hit, stalls, …) plus a dedicated cycle counter.
- On halt, freezes all counts and streams them out through a valid/ready dump port, so any consumer (bench or debug unit) can collect them.
- Adds configurable saturate/wrap arithmetic and sticky per-channel overflow flags.

Parameters:
- NUM_CH, 8: number of event channels (1..15).
- CNT_W, 32: width of every counter, including the cycle counter (8..32).
- SATURATE, 0: 1 = counters stick at all-ones; 0 = counters wrap to zero.
- IDX_W, 4: width of dump_idx; must satisfy 2**IDX_W > NUM_CH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all counters, flags and state
- en  in  1  global count enable
- evt  in  NUM_CH  event strobes, one per channel, sampled each clk
- halt  in  1  processor halt strobe
- dump_valid  out  1  dump word is valid
- dump_ready  in  1  consumer accepts the dump word
- dump_idx  out  IDX_W  index of the dump word: 0..NUM_CH-1 = event channels; NUM_CH = cycle counter
- dump_data  out  CNT_W  counter value for dump_idx
- ovf  out  NUM_CH+1  sticky overflow flags; bit NUM_CH = cycle counter
- done  out  1  dump complete, counts frozen

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. On reset:
  - all counters = 0, ovf = 0, dump pointer = 0, state = RUN;
  - dump_valid = 0, dump_idx = 0, dump_data = 0, done = 0.
- States: RUN, DUMP, DONE.
- RUN, per cycle with en=1:
  - cnt[i] += evt[i] for each channel;
  - cycle counter += 1.
  - With en=0, nothing counts.
  - halt=1: events and the cycle of that same cycle are still counted, and the next state is DUMP. Counts include the halt cycle.
- DUMP:
  - counters frozen; evt, en and halt are ignored;
  - dump_valid=1, dump_idx=ptr, dump_data=value at ptr (registered, valid in the same cycle as dump_valid);
  - on dump_valid && dump_ready: if ptr==NUM_CH, go to DONE; otherwise ptr++;
  - while dump_ready=0, the word holds stable. A consumer may hold ready high, giving one word per cycle: NUM_CH+1 cycles total.
- DONE:
  - done=1, dump_valid=0, counters frozen;
  - stays in DONE until clr or rst. Further halt pulses are ignored.
- clr:
  - valid in any state; takes effect at the next edge, with the same values as reset;
  - highest priority over halt, evt and handshake;
  - events in the clr cycle are not counted.
- Arithmetic, on an increment at value all-ones:
  - SATURATE=1: value holds at all-ones, and ovf bit is set;
  - SATURATE=0: value wraps to 0, and ovf bit is set.
  - ovf is sticky until clr or rst, and is readable in all states.
- Simultaneous halt and clr: clr wins; state is RUN.
- rst asserted mid-dump: dump aborts immediately and all outputs reset asynchronously.
- No combinational path from evt or halt to any output; all outputs are registered.

Test Plan:
- Count and dump: NUM_CH=4, CNT_W=8. Pulse evt=4'b0101 for 10 cycles, then halt.
  - Dump yields idx0=10, idx1=0, idx2=10, idx3=0, idx4 = cycles since reset incl. the halt cycle.
  - done=1 after 5 handshakes with ready held high.
- Halt-cycle capture: evt[1]=1 only in the halt cycle -> dump idx1 = 1.
- Backpressure: dump_ready=0 for 3 cycles on idx2 -> dump_idx and dump_data are stable for those cycles, and no word is skipped or duplicated.
- Wrap vs saturate: CNT_W=8, evt[0] held for 257 cycles.
  - SATURATE=0 -> idx0 = 1, ovf[0] = 1.
  - SATURATE=1 -> idx0 = 255, ovf[0] = 1.
- clr priority: clr and halt in the same cycle -> next cycle state is RUN, all counts 0, dump_valid = 0, ovf = 0.
- Async reset mid-dump: assert rst between clk edges at idx1 -> dump_valid and done go to 0 without a clk edge; after release, counting restarts from 0.
